// File: rtl/clint_ctrl.sv
// clint_ctrl: trap/interrupt sequencer driving the CSR file's CLINT write port and fetch redirect
module clint_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        inst_ecall,
  input  logic        inst_ebreak,
  input  logic        inst_mret,
  input  logic        irq_ext,
  input  logic        interrupt_enable,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] csr_mtvec,
  input  logic        csr_we_ex,
  output logic        we_clint,
  output logic [11:0] wa_clint,
  output logic [31:0] wd_clint,
  output logic        clint_hold,
  output logic        clint_jump,
  output logic [31:0] clint_jump_addr
);
  typedef enum logic [2:0] {IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, MRET_MSTATUS, JUMP} state_t;
  state_t      r_state;
  logic [31:0] r_epc, r_cause, r_target;
  logic        w_trap, w_mret, w_irq, w_event, w_wr, w_issue;
  logic [31:0] w_ms_trap, w_ms_mret;
  assign w_trap    = id_valid & (inst_ecall | inst_ebreak);
  assign w_mret    = id_valid & inst_mret & ~w_trap;
  assign w_irq     = id_valid & irq_ext & interrupt_enable & ~w_trap & ~inst_mret;
  assign w_event   = (r_state == IDLE) & (w_trap | w_mret | w_irq);
  assign w_wr      = (r_state == WR_MEPC) | (r_state == WR_MCAUSE) | (r_state == WR_MSTATUS) | (r_state == MRET_MSTATUS);
  assign w_issue   = w_wr & ~csr_we_ex;
  assign w_ms_trap = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4], 1'b0, csr_mstatus[2:0]};
  assign w_ms_mret = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4], csr_mstatus[7], csr_mstatus[2:0]};
  // write port and redirect outputs; EX-stage CSR writes win the shared port
  always_comb begin
    we_clint        = w_issue;
    wa_clint        = !w_issue ? 12'h000 :
                      r_state == WR_MEPC   ? 12'h341 :
                      r_state == WR_MCAUSE ? 12'h342 : 12'h300;
    wd_clint        = !w_issue ? 32'h0 :
                      r_state == WR_MEPC    ? r_epc :
                      r_state == WR_MCAUSE  ? r_cause :
                      r_state == WR_MSTATUS ? w_ms_trap : w_ms_mret;
    clint_hold      = (r_state != IDLE) | w_event;
    clint_jump      = r_state == JUMP;
    clint_jump_addr = (r_state == JUMP) ? r_target : 32'h0;
  end
  // sequencer: capture the event, step one CSR write per free port cycle, then redirect once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_epc    <= 32'h0;
      r_cause  <= 32'h0;
      r_target <= 32'h0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_trap | w_irq) begin
            r_epc   <= id_pc;
            r_cause <= w_irq ? 32'h8000_000B : inst_ecall ? 32'd11 : 32'd3;
            r_state <= WR_MEPC;
          end else if (w_mret) r_state <= MRET_MSTATUS;
        end
        WR_MEPC:   if (!csr_we_ex) r_state <= WR_MCAUSE;
        WR_MCAUSE: if (!csr_we_ex) r_state <= WR_MSTATUS;
        WR_MSTATUS: if (!csr_we_ex) begin
          r_target <= {csr_mtvec[31:2], 2'b00};
          r_state  <= JUMP;
        end
        MRET_MSTATUS: if (!csr_we_ex) begin
          r_target <= csr_mepc;
          r_state  <= JUMP;
        end
        JUMP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clint_ctrl.sv
// tb_clint_ctrl: randomized check of clint_ctrl against a queue-based trap sequence model
module tb_clint_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        id_valid = 0, inst_ecall = 0, inst_ebreak = 0, inst_mret = 0;
  logic        irq_ext = 0, interrupt_enable = 0, csr_we_ex = 0;
  logic [31:0] id_pc = 0, csr_mstatus = 0, csr_mepc = 0, csr_mtvec = 0;
  logic        we_clint, clint_hold, clint_jump;
  logic [11:0] wa_clint;
  logic [31:0] wd_clint, clint_jump_addr;
  int          checks = 0, failures = 0;

  typedef struct { logic [11:0] a; logic [31:0] d; int k; } wr_t;

  clint_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak), .inst_mret(inst_mret),
    .irq_ext(irq_ext), .interrupt_enable(interrupt_enable),
    .csr_mstatus(csr_mstatus), .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec),
    .csr_we_ex(csr_we_ex), .we_clint(we_clint), .wa_clint(wa_clint), .wd_clint(wd_clint),
    .clint_hold(clint_hold), .clint_jump(clint_jump), .clint_jump_addr(clint_jump_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(logic we, logic [11:0] wa, logic [31:0] wd, logic hold, logic jmp, logic [31:0] addr);
    chk("we", we_clint, we);
    chk("wa", wa_clint, wa);
    chk("wd", wd_clint, wd);
    chk("hold", clint_hold, hold);
    chk("jump", clint_jump, jmp);
    if (jmp) chk("jaddr", clint_jump_addr, addr);
  endtask

  function automatic logic [31:0] ms_trap(logic [31:0] m);
    return (m & ~32'h88) | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] ms_mret(logic [31:0] m);
    return (m & ~32'h8) | 32'h80 | (m[7] ? 32'h8 : 32'h0);
  endfunction

  task automatic junk();
    id_valid = 1'($urandom); inst_ecall = 1'($urandom); inst_ebreak = 1'($urandom);
    inst_mret = 1'($urandom); irq_ext = 1'($urandom); interrupt_enable = 1'($urandom);
    id_pc = $urandom; csr_mstatus = $urandom; csr_mtvec = $urandom; csr_mepc = $urandom;
  endtask

  task automatic clear();
    id_valid = 0; inst_ecall = 0; inst_ebreak = 0; inst_mret = 0;
    irq_ext = 0; interrupt_enable = 0; csr_we_ex = 0;
  endtask

  // kind: 0 ecall, 1 ebreak, 2 irq, 3 mret, 4 ecall+irq, 5 ecall+ebreak, 6 nothing to take
  task automatic run(int kind, logic [31:0] pc, bit rnd, int mc_stalls);
    wr_t q[$];
    wr_t e;
    logic [31:0] tgt, d, cause;
    int stalls = 0;
    @(posedge clk); #1;
    clear();
    if (rnd) begin
      csr_mstatus = $urandom; csr_mtvec = $urandom; csr_mepc = $urandom;
      csr_we_ex = 1'($urandom);
      if (kind != 2 && kind != 6) begin irq_ext = 1'($urandom); interrupt_enable = 1'($urandom); end
    end
    id_pc = pc;
    id_valid = 1;
    case (kind)
      0: inst_ecall = 1;
      1: inst_ebreak = 1;
      2: begin irq_ext = 1; interrupt_enable = 1; end
      3: inst_mret = 1;
      4: begin inst_ecall = 1; irq_ext = 1; interrupt_enable = 1; end
      5: begin inst_ecall = 1; inst_ebreak = 1; end
      default: begin
        irq_ext = 1;
        interrupt_enable = rnd ? 1'($urandom) : 1'b0;
        id_valid = !interrupt_enable;
      end
    endcase
    cause = (kind == 1) ? 32'd3 : (kind == 2) ? 32'h8000_000B : 32'd11;
    @(negedge clk);
    if (kind == 6) begin
      chk_out(0, 0, 0, 0, 0, 0);
      return;
    end
    chk_out(0, 0, 0, 1, 0, 0);
    if (kind == 3) q.push_back('{12'h300, 32'h0, 2});
    else begin
      q.push_back('{12'h341, pc, 0});
      q.push_back('{12'h342, cause, 0});
      q.push_back('{12'h300, 32'h0, 1});
    end
    tgt = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      if (rnd) begin
        junk();
        csr_we_ex = (stalls < 3) && ($urandom_range(0, 2) == 0);
      end else begin
        clear();
        csr_we_ex = (q[0].a == 12'h342) && (stalls < mc_stalls);
      end
      @(negedge clk);
      if (csr_we_ex) begin
        stalls++;
        chk_out(0, 0, 0, 1, 0, 0);
      end else begin
        e = q.pop_front();
        d = e.k == 1 ? ms_trap(csr_mstatus) : e.k == 2 ? ms_mret(csr_mstatus) : e.d;
        if (e.k == 1) tgt = csr_mtvec & ~32'h3;
        if (e.k == 2) tgt = csr_mepc;
        chk_out(1, e.a, d, 1, 0, 0);
      end
    end
    @(posedge clk); #1;
    if (rnd) begin junk(); csr_we_ex = 1'($urandom); end else clear();
    @(negedge clk);
    chk_out(0, 0, 0, 1, 1, tgt);
    @(posedge clk); #1;
    clear();
    @(negedge clk);
    chk_out(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #12;
    chk_out(0, 0, 0, 0, 0, 0);
    chk("rst_jaddr", clint_jump_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    csr_mstatus = 32'h8; csr_mtvec = 32'h0000_2001;
    run(0, 32'h100, 0, 0);
    csr_mstatus = 32'h80; csr_mepc = 32'h104;
    run(3, 32'h200, 0, 0);
    run(6, 32'h0, 0, 0);
    csr_mstatus = 32'h8; csr_mtvec = 32'h0000_3000;
    run(2, 32'h40, 0, 0);
    run(4, 32'h80, 0, 0);
    run(1, 32'h90, 0, 2);
    // reset in the middle of a trap, during the mcause write
    @(posedge clk); #1;
    clear(); id_valid = 1; inst_ecall = 1; id_pc = 32'h500;
    @(negedge clk);
    chk_out(0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    clear();
    @(negedge clk);
    chk_out(1, 12'h341, 32'h500, 1, 0, 0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk_out(0, 0, 0, 0, 0, 0);
    chk("rst_mid_jaddr", clint_jump_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out(0, 0, 0, 0, 0, 0);
    end
    run(0, 32'h600, 0, 0);
    for (int i = 0; i < 250; i++) run($urandom_range(0, 6), $urandom, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clint_ctrl.md
# clint_ctrl

Core-local interrupt/trap controller for the pipelined core, sitting next to the CSR register file in ID. It detects ecall/ebreak/mret in ID and level-sensitive external interrupts, then stalls the front end. It sequences the trap CSR updates (mepc, mcause, mstatus) through the CSR file's shared CLINT write port, one register per cycle, and then redirects fetch to mtvec or mepc.

## Interface
- No parameters. CSR addresses are fixed: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction (not a bubble)
- id_pc  in  32  PC of the instruction in ID
- inst_ecall / inst_ebreak / inst_mret  in  1 each  decoded in ID; qualified by id_valid
- irq_ext  in  1  external interrupt request, level
- interrupt_enable  in  1  mstatus.MIE from CSR file
- csr_mstatus / csr_mepc / csr_mtvec  in  32 each  live CSR values from CSR file
- csr_we_ex  in  1  EX stage CSR write this cycle; it has priority at the CSR write port
- we_clint  out  1  CSR write enable
- wa_clint  out  12  CSR write address
- wd_clint  out  32  CSR write data
- clint_hold  out  1  stall IF/ID and bubble ID→EX
- clint_jump  out  1  one-cycle fetch redirect
- clint_jump_addr  out  32  redirect target

## Operation
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, MRET_MSTATUS, JUMP.
- Event detection in IDLE, in priority order:
  - id_valid & (inst_ecall | inst_ebreak) → trap.
  - Else id_valid & inst_mret → mret.
  - Else irq_ext & interrupt_enable & id_valid → interrupt.
  - Without id_valid, an interrupt waits for the next valid instruction.
- On a trap or interrupt, capture epc_q = id_pc and the cause in cause_q:
  - ecall → 32'd11
  - ebreak → 32'd3
  - interrupt → 32'h8000_000B
  - Go to WR_MEPC.
- On mret, go to MRET_MSTATUS.
- WR_MEPC writes 0x341 = epc_q, then goes to WR_MCAUSE.
- WR_MCAUSE writes 0x342 = cause_q, then goes to WR_MSTATUS.
- WR_MSTATUS writes 0x300 = csr_mstatus with bit7 (MPIE) = csr_mstatus[3] and bit3 (MIE) = 0. Next state is JUMP with target = {csr_mtvec[31:2], 2'b00}; direct mode only.
- MRET_MSTATUS writes 0x300 = csr_mstatus with bit3 = csr_mstatus[7] and bit7 = 1. Next state is JUMP with target = csr_mepc.
- JUMP: clint_jump = 1 and clint_jump_addr = target_q for exactly one cycle, then IDLE.
- Write-port contention: in any write state with csr_we_ex = 1, we_clint = 0 and the state holds. The write issues on the first cycle with csr_we_ex = 0. mstatus data is computed from csr_mstatus in the issuing cycle, so a preceding csrw is not lost.
- Bits of mstatus other than 3 and 7 pass through unchanged.
- irq_ext, ecall, ebreak and mret are ignored outside IDLE. No nesting; MIE is cleared by the sequence anyway.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, epc_q / cause_q / target_q = 0. All outputs are 0.
- clint_hold is combinational: 1 in IDLE in the same cycle an event is detected, and 1 in every non-IDLE state including JUMP. It is 0 otherwise.
- we_clint, wa_clint and wd_clint are combinational from state and the captured registers. wa_clint and wd_clint are 0 whenever we_clint = 0.
- Trap latency with no contention: detect at cycle T. Writes at T+1 (mepc), T+2 (mcause), T+3 (mstatus). clint_jump at T+4; hold drops at T+5.
- mret latency: detect at T. mstatus write at T+1, clint_jump at T+2.
- Each cycle with csr_we_ex = 1 during a write state adds one cycle.
- rst_n asserted mid-sequence aborts immediately. No partial write completes after reset, and no jump is issued.
- target_q is registered at the mstatus-write cycle. Later CSR changes do not affect the jump address.

## Test plan
- Reset, then ecall with id_pc = 0x0000_0100, mtvec = 0x0000_2001, mstatus = 0x8 → writes 0x341 = 0x100, 0x342 = 11, 0x300 = 0x80 on T+1..T+3. clint_jump at T+4 to 0x2000; hold high T..T+4.
- mret with mstatus = 0x80, mepc = 0x104 → T+1 writes 0x300 = 0x88. T+2 jumps to 0x104.
- irq_ext = 1 with MIE = 0 → no action, hold = 0. Set MIE = 1 with id_pc = 0x40 → mepc 0x40, mcause 0x8000_000B, mstatus MIE cleared / MPIE set, jump to mtvec.
- ecall and irq_ext in the same cycle → mcause = 11. The interrupt is not taken during the sequence.
- csr_we_ex held high for 2 cycles during WR_MCAUSE → we_clint = 0 for those cycles. mcause is written on the third cycle and the jump is delayed by 2.
- rst_n pulsed low during WR_MCAUSE → all outputs 0 immediately. No mstatus write and no jump follow; the next ecall runs the full sequence.
